// File: rtl/irq_ctrl_pkg.sv
// Shared constants and types for the external interrupt controller.
package irq_ctrl_pkg;

  localparam logic [3:0] ADDR_ENABLE  = 4'h0;
  localparam logic [3:0] ADDR_PENDING = 4'h4;
  localparam logic [3:0] ADDR_CLAIM   = 4'h8;
  localparam logic [3:0] ADDR_EOI     = 4'hC;

  localparam int         ID_W       = 5;
  localparam logic [4:0] CLAIM_NONE = 5'd0;

  typedef enum logic {
    IDLE    = 1'b0,
    CLAIMED = 1'b1
  } state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one asynchronous interrupt line plus a rising-edge detector.
module irq_sync_edge (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic rise_o
);

  logic sync1, sync2, sync2_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= async_i;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign rise_o = sync2 & ~sync2_d;

endmodule

// File: rtl/irq_ctrl.sv
// Machine external interrupt controller: edge-latched pending bits, enable mask,
// fixed-priority claim on the CSR ack pulse, and a small software register file.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               ack_i,
  output logic               meip_o,
  input  logic [3:0]         addr_i,
  input  logic               wen_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o
);

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] enable_q;
  logic [NUM_IRQ-1:0] req;
  logic [NUM_IRQ-1:0] win_onehot;
  logic [NUM_IRQ-1:0] clr_mask;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    claim_id_q;
  logic               win_valid;
  logic               wr_enable, wr_pending, wr_eoi;
  logic               claim_take, claim_spur;
  logic               meip_d;
  logic [31:0]        rdata_d;
  state_t             state_q, state_d;
  logic               unused_wdata;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .async_i (irq_i[g]),
      .rise_o  (rise[g])
    );
  end

  assign wr_enable    = wen_i && (addr_i == ADDR_ENABLE);
  assign wr_pending   = wen_i && (addr_i == ADDR_PENDING);
  assign wr_eoi       = wen_i && (addr_i == ADDR_EOI);
  assign unused_wdata = ^wdata_i[31:NUM_IRQ];

  assign req       = pending_q & enable_q;
  assign win_valid = |req;

  // Scan from the top so the lowest requesting index is the last one written.
  always_comb begin
    win_onehot = '0;
    win_id     = CLAIM_NONE;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
        win_id        = ID_W'(i + 1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    meip_d     = 1'b0;
    claim_take = 1'b0;
    claim_spur = 1'b0;
    case (state_q)
      IDLE: begin
        meip_d = win_valid;
        if (ack_i) begin
          if (win_valid) begin
            claim_take = 1'b1;
            meip_d     = 1'b0;
            state_d    = CLAIMED;
          end else begin
            claim_spur = 1'b1;
          end
        end
      end
      CLAIMED: begin
        if (wr_eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A fresh edge always wins over a claim or W1C clear in the same cycle.
  assign clr_mask  = (wr_pending ? wdata_i[NUM_IRQ-1:0] : '0) |
                     (claim_take ? win_onehot : '0);
  assign pending_d = (pending_q & ~clr_mask) | rise;

  always_comb begin
    rdata_d = 32'd0;
    case (addr_i)
      ADDR_ENABLE:  rdata_d = 32'(enable_q);
      ADDR_PENDING: rdata_d = 32'(pending_q);
      ADDR_CLAIM:   rdata_d = 32'(claim_id_q);
      default:      rdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      enable_q   <= '0;
      claim_id_q <= CLAIM_NONE;
      meip_o     <= 1'b0;
      rdata_o    <= 32'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      meip_o    <= meip_d;
      rdata_o   <= rdata_d;
      if (wr_enable) enable_q <= wdata_i[NUM_IRQ-1:0];
      if (claim_take)      claim_id_q <= win_id;
      else if (claim_spur) claim_id_q <= CLAIM_NONE;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed scoreboard bench for irq_ctrl: stimulus queues expected meip/rdata values,
// a monitor compares them one cycle later.
module tb_irq_ctrl;

  localparam logic [3:0] A_EN  = 4'h0;
  localparam logic [3:0] A_PND = 4'h4;
  localparam logic [3:0] A_CLM = 4'h8;
  localparam logic [3:0] A_EOI = 4'hC;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [7:0]  irq_i = '0;
  logic        ack_i = 1'b0;
  logic        meip_o;
  logic [3:0]  addr_i = '0;
  logic        wen_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;

  typedef struct {
    int          due;
    bit          is_meip;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cycle = 0;
  int   num_checks = 0;
  int   num_fail = 0;

  irq_ctrl #(.NUM_IRQ(8)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .irq_i   (irq_i),
    .ack_i   (ack_i),
    .meip_o  (meip_o),
    .addr_i  (addr_i),
    .wen_i   (wen_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: every entry is due exactly one edge after it was queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      while (sb.size() > 0 && sb[0].due <= cycle) begin
        e = sb.pop_front();
        if (e.due < cycle) begin
          num_checks++;
          num_fail++;
          $display("[TB] FAIL %s: stale entry due %0d seen at %0d", e.name, e.due, cycle);
        end else if (e.is_meip) begin
          checkOutput(e.name, {31'd0, meip_o}, e.exp);
        end else begin
          checkOutput(e.name, rdata_o, e.exp);
        end
      end
    end
  end

  task automatic expectRead(input logic [31:0] exp, input string name);
    exp_t e;
    e.due = cycle + 1; e.is_meip = 1'b0; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  task automatic expectMeip(input logic exp, input string name);
    exp_t e;
    e.due = cycle + 1; e.is_meip = 1'b1; e.exp = {31'd0, exp}; e.name = name;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [7:0] irq, input logic ack, input logic wen,
                               input logic [3:0] addr, input logic [31:0] wdata,
                               input logic rst);
    @(negedge clk_i);
    irq_i   = irq;
    ack_i   = ack;
    wen_i   = wen;
    addr_i  = addr;
    wdata_i = wdata;
    reset_i = rst;
  endtask

  task automatic idle(input logic [7:0] irq, input logic [3:0] addr);
    applyStimulus(irq, 1'b0, 1'b0, addr, 32'd0, 1'b0);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    applyStimulus(8'h00, 1'b0, 1'b1, addr, data, 1'b0);
  endtask

  task automatic ack();
    applyStimulus(8'h00, 1'b1, 1'b0, A_EN, 32'd0, 1'b0);
  endtask

  initial begin
    applyStimulus(8'h00, 1'b0, 1'b0, A_EN, 32'd0, 1'b1);
    expectMeip(1'b0, "reset_meip"); expectRead(32'd0, "reset_rdata");
    idle(8'h00, A_PND); expectRead(32'd0, "reset_pending");

    // Single source 2 (ID 3): latency and claim.
    wr(A_EN, 32'h05);
    idle(8'h00, A_EN); expectRead(32'h05, "enable_rd");
    idle(8'h04, A_EN); expectMeip(1'b0, "t1_meip_k");
    idle(8'h00, A_EN); expectMeip(1'b0, "t1_meip_k1");
    idle(8'h00, A_PND); expectRead(32'h00, "t1_pend_k2"); expectMeip(1'b0, "t1_meip_k2");
    idle(8'h00, A_PND); expectRead(32'h04, "t1_pend_k3"); expectMeip(1'b1, "t1_meip_k3");
    ack(); expectMeip(1'b0, "t1_meip_ack");
    idle(8'h00, A_CLM); expectRead(32'd3, "t1_claim");
    idle(8'h00, A_PND); expectRead(32'd0, "t1_pend_after");
    wr(A_EOI, 32'hDEAD); expectMeip(1'b0, "t1_meip_eoi");
    idle(8'h00, A_EN); expectMeip(1'b0, "t1_meip_quiet");

    // Sources 0 and 2 together: priority, then EOI re-raises meip.
    idle(8'h05, A_EN);
    idle(8'h00, A_EN);
    idle(8'h00, A_EN);
    idle(8'h00, A_EN); expectMeip(1'b1, "t2_meip");
    ack(); expectMeip(1'b0, "t2_meip_ack");
    idle(8'h00, A_CLM); expectRead(32'd1, "t2_claim1");
    idle(8'h00, A_PND); expectRead(32'h04, "t2_pend");
    wr(A_EOI, 32'd0); expectMeip(1'b0, "t2_meip_eoi");
    idle(8'h00, A_EN); expectMeip(1'b1, "t2_meip_reraise");
    ack();
    idle(8'h00, A_CLM); expectRead(32'd3, "t2_claim2"); expectMeip(1'b0, "t2_meip_ack2");
    wr(A_EOI, 32'd0);

    // Masked source 1, then enable toggling.
    wr(A_EN, 32'h00);
    idle(8'h02, A_EN);
    idle(8'h00, A_EN);
    idle(8'h00, A_EN);
    idle(8'h00, A_PND); expectRead(32'h02, "t3_pend"); expectMeip(1'b0, "t3_meip_masked");
    wr(A_EN, 32'h02); expectMeip(1'b0, "t3_meip_wr_edge");
    idle(8'h00, A_EN); expectMeip(1'b1, "t3_meip_enabled");
    wr(A_EN, 32'h00); expectMeip(1'b1, "t3_meip_prewrite");
    idle(8'h00, A_EN); expectMeip(1'b0, "t3_meip_dropped");
    wr(A_EN, 32'h03);
    idle(8'h00, A_EN); expectMeip(1'b1, "t3_meip_reen");
    ack(); expectMeip(1'b0, "t3_meip_ack");

    // Edge and ack while CLAIMED.
    applyStimulus(8'h01, 1'b1, 1'b0, A_EN, 32'd0, 1'b0); expectMeip(1'b0, "t4_meip_nest");
    idle(8'h00, A_EN);
    idle(8'h00, A_EN);
    applyStimulus(8'h00, 1'b1, 1'b0, A_CLM, 32'd0, 1'b0);
    expectRead(32'd2, "t4_claim_kept"); expectMeip(1'b0, "t4_meip_held");
    idle(8'h00, A_PND); expectRead(32'h01, "t4_pend");
    wr(A_EOI, 32'd0); expectMeip(1'b0, "t4_meip_eoi");
    idle(8'h00, A_EN); expectMeip(1'b1, "t4_meip_after_eoi");
    ack();
    idle(8'h00, A_CLM); expectRead(32'd1, "t4_claim");
    wr(A_EOI, 32'd0);
    idle(8'h00, A_EN); expectMeip(1'b0, "t4_meip_quiet");

    // W1C on source 3, including a coincident new edge and a held level.
    idle(8'h08, A_EN);
    idle(8'h00, A_EN);
    idle(8'h00, A_EN);
    idle(8'h00, A_PND); expectRead(32'h08, "t5_pend_set");
    wr(A_PND, 32'h08);
    idle(8'h00, A_PND); expectRead(32'h00, "t5_w1c");
    idle(8'h08, A_EN);
    idle(8'h08, A_EN);
    applyStimulus(8'h08, 1'b0, 1'b1, A_PND, 32'h08, 1'b0);
    idle(8'h08, A_PND); expectRead(32'h08, "t5_set_wins");
    applyStimulus(8'h08, 1'b0, 1'b1, A_PND, 32'h08, 1'b0);
    idle(8'h08, A_PND); expectRead(32'h00, "t5_level_no_retrig1");
    idle(8'h08, A_PND); expectRead(32'h00, "t5_level_no_retrig2");
    idle(8'h00, A_EN);

    // Spurious ack, then reset during CLAIMED.
    ack();
    idle(8'h00, A_CLM); expectRead(32'd0, "t6_spurious_claim");
    idle(8'h01, A_EN);
    idle(8'h00, A_EN);
    idle(8'h00, A_EN);
    idle(8'h00, A_EN); expectMeip(1'b1, "t6_idle_after_spur");
    ack();
    applyStimulus(8'h00, 1'b0, 1'b0, A_EN, 32'd0, 1'b1);
    expectMeip(1'b0, "t6_meip_reset"); expectRead(32'd0, "t6_rdata_reset");
    idle(8'h00, A_EN); expectRead(32'd0, "t6_enable_reset");
    idle(8'h00, A_PND); expectRead(32'd0, "t6_pend_reset");
    idle(8'h00, A_CLM); expectRead(32'd0, "t6_claim_reset"); expectMeip(1'b0, "t6_meip_after");

    // Enable upper bits, EOI readback, highest source ID.
    wr(A_EN, 32'hFFFF_FFFF);
    idle(8'h00, A_EN); expectRead(32'h0000_00FF, "t7_enable_mask");
    idle(8'h80, A_EOI); expectRead(32'd0, "t7_eoi_read");
    idle(8'h00, A_EN);
    idle(8'h00, A_EN);
    idle(8'h00, A_EN); expectMeip(1'b1, "t7_meip");
    ack();
    idle(8'h00, A_CLM); expectRead(32'd8, "t7_claim8");

    for (int i = 0; i < 8 && sb.size() > 0; i++) @(posedge clk_i);
    #2;
    if (sb.size() != 0) begin
      num_checks++;
      num_fail++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
